// File: rtl/regfile_psr_pkg.sv
// Shared definitions for the register file / PSR slice: datapath widths,
// PSR flag bit positions, ALU opcode constants and the masked flag merge.
package regfile_psr_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 16;
  localparam int ADDR_W  = 4;
  localparam int FLAG_W  = 5;

  // Flag bit positions, shared by the ALU flag bus and the PSR.
  localparam int FLAG_C = 0;  // carry
  localparam int FLAG_L = 1;  // unsigned less-than
  localparam int FLAG_F = 2;  // signed overflow
  localparam int FLAG_Z = 3;  // zero
  localparam int FLAG_N = 4;  // negative

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [FLAG_W-1:0] flags_t;

  // ALU opcode constants. The ALU lives outside this slice; the values are
  // kept here so the decoder and the datapath agree on one encoding.
  localparam logic [3:0] ADD  = 4'h0;
  localparam logic [3:0] ADDU = 4'h1;
  localparam logic [3:0] ADDC = 4'h2;
  localparam logic [3:0] SUB  = 4'h3;
  localparam logic [3:0] SUBC = 4'h4;
  localparam logic [3:0] CMP  = 4'h5;
  localparam logic [3:0] AND  = 4'h6;
  localparam logic [3:0] OR   = 4'h7;
  localparam logic [3:0] XOR  = 4'h8;
  localparam logic [3:0] NOT  = 4'h9;
  localparam logic [3:0] MOV  = 4'hA;
  localparam logic [3:0] LSH  = 4'hB;
  localparam logic [3:0] RSH  = 4'hC;
  localparam logic [3:0] ALSH = 4'hD;
  localparam logic [3:0] ARSH = 4'hE;

  // Take each bit from fresh when its mask bit is set, else keep old.
  function automatic flags_t merge_flags(input flags_t old_flags,
                                         input flags_t fresh,
                                         input flags_t mask);
    return (old_flags & ~mask) | (fresh & mask);
  endfunction

endpackage

// File: rtl/regfile_psr_psr_reg.sv
// psr_reg: 5-bit processor status register with per-bit update enables
// and synchronous active-high reset.
module psr_reg
  import regfile_psr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] flags_mask,
  output logic [FLAG_W-1:0] psr
);

  // Clear on reset, otherwise load only the masked-in flag bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      psr <= '0;
    end else begin
      psr <= merge_flags(psr, flags_in, flags_mask);
    end
  end

endmodule

// File: rtl/regfile_psr.sv
// regfile_psr: 16 x 16-bit general-purpose register file with two
// combinational read ports, one write port and the processor status
// register.
// Build option: define RF_BYPASS_EN to forward wr_data to a read port that
// addresses the register being written in the same cycle; without it a read
// returns the stored (pre-write) value.
module regfile_psr
  import regfile_psr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] flags_mask,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [FLAG_W-1:0] psr
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // Per-register write decode. The decode is qualified by wr_en, so an
  // unknown wr_addr while wr_en is low never selects a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_CNT; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic hit_a;
  logic hit_b;

  // Write-through: a read that targets the register being written this
  // cycle sees the incoming data rather than the stored value.
  always_comb begin
    hit_a     = wr_en && !reset && (rd_addr_a == wr_addr);
    hit_b     = wr_en && !reset && (rd_addr_b == wr_addr);
    rd_data_a = hit_a ? wr_data : regs[rd_addr_a];
    rd_data_b = hit_b ? wr_data : regs[rd_addr_b];
  end
`else
  // Reads come straight from stored state; a write becomes visible on
  // the cycle after its edge.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
  end
`endif

  psr_reg u_psr_reg (
    .clk        (clk),
    .reset      (reset),
    .flags_in   (flags_in),
    .flags_mask (flags_mask),
    .psr        (psr)
  );

endmodule

// File: tb/tb_regfile_psr.sv
// tb_regfile_psr: self-checking bench for regfile_psr. A reference array
// and PSR track the architectural state; expected read values are queued
// when reads are issued and compared when the outputs settle.
module tb_regfile_psr;

  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [4:0]    flags_in;
  logic [4:0]    flags_mask;
  logic [3:0]    rd_addr_a;
  logic [3:0]    rd_addr_b;
  logic [W-1:0]  rd_data_a;
  logic [W-1:0]  rd_data_b;
  logic [4:0]    psr;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  m_regs [16];
  logic [4:0]    m_psr;
  int            checks;
  int            failures;

  regfile_psr dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flags_in   (flags_in),
    .flags_mask (flags_mask),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .psr        (psr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every driver task starts and ends 1 time unit after a rising edge.
  task automatic idle_inputs();
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    flags_in   = '0;
    flags_mask = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;
  endtask

  // One cycle of write and/or PSR update, mirrored into the reference.
  task automatic drive_cycle(input logic we, input logic [3:0] addr,
                             input logic [W-1:0] data, input logic [4:0] fl,
                             input logic [4:0] mask);
    wr_en      = we;
    wr_addr    = addr;
    wr_data    = data;
    flags_in   = fl;
    flags_mask = mask;
    tick();
    if (we) m_regs[addr] = data;
    m_psr = (m_psr & ~mask) | (fl & mask);
    idle_inputs();
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [W-1:0] data);
    drive_cycle(1'b1, addr, data, 5'b0, 5'b0);
  endtask

  // Issue a read on both ports; expected values are queued at issue time.
  task automatic read_pair(input string tag, input logic [3:0] a,
                           input logic [3:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
    exp_q.push_back(m_regs[a]);
    exp_q.push_back(m_regs[b]);
    #1;
    check({tag, "_a"}, rd_data_a, exp_q.pop_front());
    check({tag, "_b"}, rd_data_b, exp_q.pop_front());
  endtask

  task automatic check_psr(input string tag);
    exp_q.push_back(W'(m_psr));
    #1;
    check(tag, W'(psr), exp_q.pop_front());
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      read_pair(tag, 4'(i), 4'(15 - i));
    end
    check_psr({tag, "_psr"});
  endtask

  initial begin
    logic [W-1:0]  a_val;
    logic [W-1:0]  b_val;
    logic [W:0]    sum;
    logic [4:0]    alu_flags;
    logic [W-1:0]  bypass_exp;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    rd_addr_a = '0;
    rd_addr_b = '0;
    idle_inputs();
    tick();
    do_reset();
    check_all("por");

    // Arbitrary writes and flag updates, then a one-cycle reset clears all.
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 4'($urandom_range(0, 15)), W'($urandom_range(1, 16'hFFFF)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    do_reset();
    check_all("rst");

    // Write/read sweep with the ports crossed.
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'hA500 + W'(i));
    for (int i = 0; i < 16; i++) begin
      read_pair("sweep", 4'(i), 4'(15 - i));
      check("sweep_const_a", rd_data_a, 16'hA500 + W'(i));
      check("sweep_const_b", rd_data_b, 16'hA50F - W'(i));
    end

    // Masked flag updates.
    do_reset();
    drive_cycle(1'b0, 4'd0, 16'h0, 5'b11111, 5'b01001);
    check("mask1", W'(psr), W'(5'b01001));
    drive_cycle(1'b0, 4'd0, 16'h0, 5'b00000, 5'b00001);
    check("mask2", W'(psr), W'(5'b01000));
    // Zero mask holds PSR even alongside a register write.
    drive_cycle(1'b1, 4'd7, 16'h1234, 5'b10111, 5'b00000);
    check_psr("mask0_psr");
    read_pair("mask0_reg", 4'd7, 4'd7);

    // Same-cycle read of the register being written.
    write_reg(4'd3, 16'h1111);
    rd_addr_a = 4'd3;
    wr_en     = 1'b1;
    wr_addr   = 4'd3;
    wr_data   = 16'h2222;
`ifdef RF_BYPASS_EN
    bypass_exp = 16'h2222;
`else
    bypass_exp = 16'h1111;
`endif
    #1;
    check("same_cycle", rd_data_a, bypass_exp);
    tick();
    m_regs[3] = 16'h2222;
    idle_inputs();
    read_pair("after_write", 4'd3, 4'd3);
    check("after_write_const", rd_data_a, 16'h2222);

    // Reset wins over a simultaneous write and flag update.
    write_reg(4'd5, 16'h5A5A);
    drive_cycle(1'b0, 4'd0, 16'h0, 5'b10101, 5'b11111);
    reset      = 1'b1;
    wr_en      = 1'b1;
    wr_addr    = 4'd5;
    wr_data    = 16'hFFFF;
    flags_in   = 5'b11111;
    flags_mask = 5'b11111;
    tick();
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;
    read_pair("rst_vs_wr", 4'd5, 4'd0);
    check("rst_vs_wr_psr", W'(psr), '0);

    // ALU loop: R1 + R2 written back to R3 with full flag update.
    write_reg(4'd1, 16'hFFFF);
    write_reg(4'd2, 16'h8000);
    read_pair("alu_src", 4'd1, 4'd2);
    a_val = m_regs[1];
    b_val = m_regs[2];
    sum   = {1'b0, a_val} + {1'b0, b_val};
    alu_flags = '0;
    alu_flags[0] = sum[W];
    alu_flags[1] = 1'b0;
    alu_flags[2] = (a_val[W-1] == b_val[W-1]) && (sum[W-1] != a_val[W-1]);
    alu_flags[3] = (sum[W-1:0] == '0);
    alu_flags[4] = sum[W-1];
    drive_cycle(1'b1, 4'd3, sum[W-1:0], alu_flags, 5'b11111);
    read_pair("alu_r3", 4'd3, 4'd1);
    check("alu_r3_const", rd_data_a, 16'h7FFF);
    check("alu_psr", W'(psr), W'(5'b00101));

    // Unknown write address with write disabled changes nothing.
    wr_en   = 1'b0;
    wr_addr = 'x;
    wr_data = 16'hDEAD;
    tick();
    idle_inputs();
    check_all("x_addr");

    // Random traffic against the reference.
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  W'($urandom_range(0, 16'hFFFF)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
      read_pair("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      check_psr("rand_psr");
    end

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
